// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller.
// Holds opcode/funct constants, the ALU operation codes (also consumed by the ALU),
// the controller state encoding and the datapath select-field encodings.
package multicycle_control_pkg;

    // Primary opcodes, instruction[31:26]
    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpXori  = 6'b001110;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    // R-type function codes, instruction[5:0]
    localparam logic [5:0] FnSll = 6'b000000;
    localparam logic [5:0] FnSrl = 6'b000010;
    localparam logic [5:0] FnSra = 6'b000011;
    localparam logic [5:0] FnJr  = 6'b001000;
    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnXor = 6'b100110;

    typedef enum logic [3:0] {
        AluAdd = 4'b0000,
        AluAnd = 4'b0001,
        AluXor = 4'b0010,
        AluSll = 4'b0011,
        AluSub = 4'b0100,
        AluOr  = 4'b0101,
        AluLui = 4'b0110,
        AluSrl = 4'b0111,
        AluSra = 4'b1111
    } alu_op_e;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StMemory,
        StWriteback,
        StTrap
    } state_e;

    // ALU A input
    localparam logic [1:0] ASelPc    = 2'd0;
    localparam logic [1:0] ASelRs    = 2'd1;
    localparam logic [1:0] ASelShamt = 2'd2;

    // ALU B input
    localparam logic [2:0] BSelRt      = 3'd0;
    localparam logic [2:0] BSelFour    = 3'd1;
    localparam logic [2:0] BSelSextImm = 3'd2;
    localparam logic [2:0] BSelZextImm = 3'd3;
    localparam logic [2:0] BSelBranch  = 3'd4;

    // PC source
    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcAluOut = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;
    localparam logic [1:0] PcSrcRs     = 2'd3;

    // Register-file destination and write-data source
    localparam logic [1:0] DstRt  = 2'd0;
    localparam logic [1:0] DstRd  = 2'd1;
    localparam logic [1:0] DstR31 = 2'd2;

    localparam logic [1:0] SrcAluOut = 2'd0;
    localparam logic [1:0] SrcMdr    = 2'd1;
    localparam logic [1:0] SrcPc     = 2'd2;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle.
// master: the controller (reads IR, zero flag, memory_ready; drives ALU code and strobes).
// slave:  the datapath/memory side.
interface multicycle_control_if;
    logic [31:0] instruction;
    logic        zero;
    logic        memory_ready;
    logic [3:0]  operation;
    logic [1:0]  a_select;
    logic [2:0]  b_select;
    logic        pc_write;
    logic [1:0]  pc_source;
    logic        ir_write;
    logic        memory_request;
    logic        memory_write;
    logic        address_select;
    logic        register_write;
    logic [1:0]  register_destination;
    logic [1:0]  register_source;
    logic        illegal;

    modport master (
        input  instruction, zero, memory_ready,
        output operation, a_select, b_select, pc_write, pc_source, ir_write,
               memory_request, memory_write, address_select, register_write,
               register_destination, register_source, illegal
    );

    modport slave (
        output instruction, zero, memory_ready,
        input  operation, a_select, b_select, pc_write, pc_source, ir_write,
               memory_request, memory_write, address_select, register_write,
               register_destination, register_source, illegal
    );
endinterface

// File: rtl/multicycle_control_alu_operation_decoder.sv
// Combinational decode of opcode/funct into the EXECUTE-cycle ALU code and operand
// selects, plus a legal flag for the supported instruction subset.
//   opcode_i, funct_i : instruction[31:26], instruction[5:0]
//   operation_o       : ALU code
//   a_select_o/b_select_o : ALU operand selects for EXECUTE
//   legal_o           : instruction is in the supported subset
module alu_operation_decoder
    import multicycle_control_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output alu_op_e    operation_o,
    output logic [1:0] a_select_o,
    output logic [2:0] b_select_o,
    output logic       legal_o
);

    always_comb begin
        operation_o = AluAdd;
        a_select_o  = ASelPc;
        b_select_o  = BSelRt;
        legal_o     = 1'b1;
        unique case (opcode_i)
            OpRType: begin
                a_select_o = ASelRs;
                unique case (funct_i)
                    FnAdd: operation_o = AluAdd;
                    FnSub: operation_o = AluSub;
                    FnAnd: operation_o = AluAnd;
                    FnOr:  operation_o = AluOr;
                    FnXor: operation_o = AluXor;
                    FnSll: begin operation_o = AluSll; a_select_o = ASelShamt; end
                    FnSrl: begin operation_o = AluSrl; a_select_o = ASelShamt; end
                    FnSra: begin operation_o = AluSra; a_select_o = ASelShamt; end
                    FnJr:  operation_o = AluAdd;
                    default: legal_o = 1'b0;
                endcase
            end
            OpAddi, OpLw, OpSw: begin
                a_select_o = ASelRs;
                b_select_o = BSelSextImm;
            end
            OpAndi: begin operation_o = AluAnd; a_select_o = ASelRs; b_select_o = BSelZextImm; end
            OpOri:  begin operation_o = AluOr;  a_select_o = ASelRs; b_select_o = BSelZextImm; end
            OpXori: begin operation_o = AluXor; a_select_o = ASelRs; b_select_o = BSelZextImm; end
            OpLui:  begin operation_o = AluLui; b_select_o = BSelZextImm; end
            OpBeq, OpBne: begin
                operation_o = AluSub;
                a_select_o  = ASelRs;
            end
            OpJ, OpJal: ;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the MIPS subset: sequences fetch/decode/execute/memory/
// writeback, handshakes with the shared memory and produces the ALU operation code and
// every datapath strobe.
//   clock  : rising-edge system clock
//   resetn : asynchronous active-low reset; forces FETCH and zeroes all outputs
//   bus    : master side of multicycle_control_if (IR, zero, memory_ready in; strobes out)
module multicycle_control
    import multicycle_control_pkg::*;
#(
    // Reserved; the FSM always restarts at FETCH.
    parameter int unsigned RESET_STATE_FETCH = 1
) (
    input logic                  clock,
    input logic                  resetn,
    multicycle_control_if.master bus
);

    localparam int unsigned unused_reset_state_fetch = RESET_STATE_FETCH;

    state_e state_q, state_d;

    alu_op_e    dec_op;
    logic [1:0] dec_a;
    logic [2:0] dec_b;
    logic       dec_legal;

    logic [5:0] opcode, funct;
    assign opcode = bus.instruction[31:26];
    assign funct  = bus.instruction[5:0];

    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instruction[25:6];

    alu_operation_decoder u_alu_operation_decoder (
        .opcode_i    (opcode),
        .funct_i     (funct),
        .operation_o (dec_op),
        .a_select_o  (dec_a),
        .b_select_o  (dec_b),
        .legal_o     (dec_legal)
    );

    logic is_rtype, is_jr, is_lw, is_sw, is_beq, is_bne, is_jump, is_jal;
    assign is_rtype = (opcode == OpRType);
    assign is_jr    = is_rtype && (funct == FnJr);
    assign is_lw    = (opcode == OpLw);
    assign is_sw    = (opcode == OpSw);
    assign is_beq   = (opcode == OpBeq);
    assign is_bne   = (opcode == OpBne);
    assign is_jal   = (opcode == OpJal);
    assign is_jump  = (opcode == OpJ) || is_jal;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    alu_op_e    op;
    logic [1:0] a_sel, pc_src, reg_dst, reg_src;
    logic [2:0] b_sel;
    logic       pc_wr, ir_wr, mem_req, mem_wr, addr_sel, reg_wr;

    always_comb begin
        state_d  = state_q;
        op       = AluAdd;
        a_sel    = ASelPc;
        b_sel    = BSelRt;
        pc_wr    = 1'b0;
        pc_src   = PcSrcAlu;
        ir_wr    = 1'b0;
        mem_req  = 1'b0;
        mem_wr   = 1'b0;
        addr_sel = 1'b0;
        reg_wr   = 1'b0;
        reg_dst  = DstRt;
        reg_src  = SrcAluOut;
        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (bus.memory_ready) begin
                    // PC + 4 computed and loaded alongside the IR write
                    ir_wr   = 1'b1;
                    b_sel   = BSelFour;
                    pc_wr   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // Speculative branch target, latched into alu_out
                b_sel = BSelBranch;
                if (!dec_legal) begin
                    state_d = StTrap;
                end else if (is_jump) begin
                    pc_wr   = 1'b1;
                    pc_src  = PcSrcJump;
                    // PC already holds the return address (+4)
                    reg_wr  = is_jal;
                    reg_dst = is_jal ? DstR31 : DstRt;
                    reg_src = is_jal ? SrcPc : SrcAluOut;
                    state_d = StFetch;
                end else if (is_jr) begin
                    pc_wr   = 1'b1;
                    pc_src  = PcSrcRs;
                    state_d = StFetch;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                op    = dec_op;
                a_sel = dec_a;
                b_sel = dec_b;
                if (is_beq || is_bne) begin
                    pc_wr   = is_beq ? bus.zero : !bus.zero;
                    pc_src  = PcSrcAluOut;
                    state_d = StFetch;
                end else if (is_lw || is_sw) begin
                    state_d = StMemory;
                end else begin
                    state_d = StWriteback;
                end
            end
            StMemory: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_wr   = is_sw;
                if (bus.memory_ready) begin
                    state_d = is_sw ? StFetch : StWriteback;
                end
            end
            StWriteback: begin
                reg_wr  = 1'b1;
                reg_dst = is_rtype ? DstRd : DstRt;
                reg_src = is_lw ? SrcMdr : SrcAluOut;
                state_d = StFetch;
            end
            StTrap: ;
            default: state_d = StFetch;
        endcase
    end

    // Outputs are forced low for as long as reset is asserted.
    assign bus.operation            = resetn ? op : 4'b0000;
    assign bus.a_select             = resetn ? a_sel : 2'd0;
    assign bus.b_select             = resetn ? b_sel : 3'd0;
    assign bus.pc_write             = resetn & pc_wr;
    assign bus.pc_source            = resetn ? pc_src : 2'd0;
    assign bus.ir_write             = resetn & ir_wr;
    assign bus.memory_request       = resetn & mem_req;
    assign bus.memory_write         = resetn & mem_wr;
    assign bus.address_select       = resetn & addr_sel;
    assign bus.register_write       = resetn & reg_wr;
    assign bus.register_destination = resetn ? reg_dst : 2'd0;
    assign bus.register_source      = resetn ? reg_src : 2'd0;
    // TRAP is exited only by reset, so this is sticky by construction.
    assign bus.illegal              = resetn && (state_q == StTrap);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with hand-computed expected values.
module tb_multicycle_control;

    logic clock;
    logic resetn;
    int   n_vec;
    int   n_miss;

    multicycle_control_if bus ();

    multicycle_control #(
        .RESET_STATE_FETCH (1)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every output except illegal, packed (21 bits).
    function automatic logic [31:0] strobes();
        return {11'd0, bus.operation, bus.a_select, bus.b_select, bus.pc_write, bus.pc_source,
                bus.ir_write, bus.memory_request, bus.memory_write, bus.address_select,
                bus.register_write, bus.register_destination, bus.register_source};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // From FETCH (memory_ready=1): DECODE, EXECUTE check, then next state's first cycle.
    task automatic run_branch(input string tag, input logic [31:0] instr, input logic z,
                              input logic exp_pcw);
        bus.instruction  = instr;
        bus.memory_ready = 1'b1;
        bus.zero         = z;
        step();
        step();
        check({tag, "_op"}, 32'(bus.operation), 32'h4);
        check({tag, "_pcw"}, 32'(bus.pc_write), 32'(exp_pcw));
        check({tag, "_pcsrc"}, 32'(bus.pc_source), 32'd1);
        step();
        check({tag, "_next_fetch"}, 32'(bus.ir_write), 32'd1);
    endtask

    task automatic run_alu(input string tag, input logic [31:0] instr, input logic [3:0] exp_op,
                           input logic [1:0] exp_a, input logic [2:0] exp_b,
                           input logic [1:0] exp_dst);
        bus.instruction  = instr;
        bus.memory_ready = 1'b1;
        step();
        step();
        check({tag, "_op"}, 32'(bus.operation), 32'(exp_op));
        check({tag, "_a"}, 32'(bus.a_select), 32'(exp_a));
        check({tag, "_b"}, 32'(bus.b_select), 32'(exp_b));
        step();
        check({tag, "_wb_wr"}, 32'(bus.register_write), 32'd1);
        check({tag, "_wb_dst"}, 32'(bus.register_destination), 32'(exp_dst));
        step();
    endtask

    initial begin
        n_vec            = 0;
        n_miss           = 0;
        resetn           = 1'b1;
        bus.instruction  = 32'h0;
        bus.zero         = 1'b0;
        bus.memory_ready = 1'b0;
        #1 resetn = 1'b0;
        #1;
        check("reset_strobes", strobes(), 32'h0);
        check("reset_illegal", 32'(bus.illegal), 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("release_req", 32'(bus.memory_request), 32'd1);
        check("release_addr", 32'(bus.address_select), 32'd0);

        // add r3,r1,r2
        bus.instruction  = 32'h0022_1820;
        bus.memory_ready = 1'b1;
        #1;
        check("add_f_irw", 32'(bus.ir_write), 32'd1);
        check("add_f_pcw", 32'(bus.pc_write), 32'd1);
        check("add_f_b", 32'(bus.b_select), 32'd1);
        step();
        check("add_d_a", 32'(bus.a_select), 32'd0);
        check("add_d_b", 32'(bus.b_select), 32'd4);
        check("add_d_pcw", 32'(bus.pc_write), 32'd0);
        step();
        check("add_x_op", 32'(bus.operation), 32'h0);
        check("add_x_a", 32'(bus.a_select), 32'd1);
        check("add_x_b", 32'(bus.b_select), 32'd0);
        step();
        check("add_w_wr", 32'(bus.register_write), 32'd1);
        check("add_w_dst", 32'(bus.register_destination), 32'd1);
        check("add_w_src", 32'(bus.register_source), 32'd0);
        step();
        check("add_cpi4_fetch", 32'(bus.ir_write), 32'd1);

        // lw r2,8(r1) with a 3-cycle memory wait
        bus.instruction = 32'h8C22_0008;
        step();
        step();
        check("lw_x_a", 32'(bus.a_select), 32'd1);
        check("lw_x_b", 32'(bus.b_select), 32'd2);
        bus.memory_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("lw_m_req", 32'(bus.memory_request), 32'd1);
            check("lw_m_we", 32'(bus.memory_write), 32'd0);
            check("lw_m_addr", 32'(bus.address_select), 32'd1);
            step();
        end
        bus.memory_ready = 1'b1;
        #1;
        check("lw_m_req_last", 32'(bus.memory_request), 32'd1);
        step();
        check("lw_w_wr", 32'(bus.register_write), 32'd1);
        check("lw_w_src", 32'(bus.register_source), 32'd1);
        check("lw_w_dst", 32'(bus.register_destination), 32'd0);
        step();

        // Reset asserted mid-MEMORY
        step();
        step();
        bus.memory_ready = 1'b0;
        step();
        check("rst_mem_req_before", 32'(bus.memory_request), 32'd1);
        resetn = 1'b0;
        #1;
        check("rst_mem_strobes", strobes(), 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("rst_mem_fetch_req", 32'(bus.memory_request), 32'd1);
        check("rst_mem_fetch_addr", 32'(bus.address_select), 32'd0);

        run_branch("beq_z1", 32'h1022_0003, 1'b1, 1'b1);
        run_branch("beq_z0", 32'h1022_0003, 1'b0, 1'b0);
        run_branch("bne_z0", 32'h1422_0003, 1'b0, 1'b1);
        run_branch("bne_z1", 32'h1422_0003, 1'b1, 1'b0);

        run_alu("sra", 32'h0002_1883, 4'hF, 2'd2, 3'd0, 2'd1);
        run_alu("lui", 32'h3C01_1234, 4'h6, 2'd0, 3'd3, 2'd0);

        // jal
        bus.instruction = 32'h0C00_0010;
        step();
        check("jal_d_wr", 32'(bus.register_write), 32'd1);
        check("jal_d_dst", 32'(bus.register_destination), 32'd2);
        check("jal_d_src", 32'(bus.register_source), 32'd2);
        check("jal_d_pcsrc", 32'(bus.pc_source), 32'd2);
        check("jal_d_pcw", 32'(bus.pc_write), 32'd1);
        step();
        check("jal_next_fetch", 32'(bus.ir_write), 32'd1);

        // Undefined opcode -> TRAP
        bus.instruction = 32'hFC00_0000;
        step();
        check("trap_d_pcw", 32'(bus.pc_write), 32'd0);
        step();
        for (int i = 0; i < 20; i++) begin
            bus.memory_ready = i[0];
            #1;
            check("trap_illegal", 32'(bus.illegal), 32'd1);
            check("trap_strobes", strobes(), 32'h0);
            step();
        end
        resetn = 1'b0;
        #1;
        check("trap_rst_illegal", 32'(bus.illegal), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("trap_rst_fetch", 32'(bus.memory_request), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle control FSM that drives the 32-bit ALU's 4-bit operation code and all datapath strobes for the MIPS subset.
- Sequences fetch / decode / execute / memory / writeback.
- Handshakes with the shared instruction/data memory.
- Sits between the instruction register and the datapath; it is the producer of the ALU operation codes the datapath consumes.

Parameters:
- RESET_STATE_FETCH, 1, reserved; must stay 1 (FSM always restarts at FETCH).

Ports:
- clock  in  1  single system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- instruction  in  32  IR contents; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- memory_ready  in  1  memory completes the current request this cycle.
- operation  out  4  ALU code: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111.
- a_select  out  2  ALU A input: 0=PC, 1=rs, 2=shamt.
- b_select  out  3  ALU B input: 0=rt, 1=const 4, 2=sext imm, 3=zext imm, 4=sext imm<<2.
- pc_write  out  1  load PC.
- pc_source  out  2  PC source: 0=ALU result, 1=alu_out register, 2=jump target, 3=rs.
- ir_write  out  1  load IR.
- memory_request  out  1  memory request strobe.
- memory_write  out  1  request is a store.
- address_select  out  1  memory address: 0=PC, 1=alu_out.
- register_write  out  1  register-file write enable.
- register_destination  out  2  destination: 0=rt, 1=rd, 2=r31.
- register_source  out  2  write data: 0=alu_out, 1=MDR, 2=PC.
- illegal  out  1  sticky undefined-instruction flag.

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP. Registered state; outputs are combinational from state, instruction, zero and memory_ready.
- Reset:
  - resetn low puts state at FETCH immediately, including mid-request.
  - While resetn is low, every output is 0 and illegal is cleared.
  - An outstanding memory request is abandoned; the memory must tolerate the request dropping.
- Default for every strobe in every state is 0 unless listed below.
- FETCH:
  - memory_request=1, address_select=0.
  - Held until memory_ready.
  - In the memory_ready cycle: ir_write=1, a=0, b=1, op ADD, pc_write=1, pc_source=0; next state DECODE.
  - Zero-wait: memory_ready in the same cycle as the request is legal.
- DECODE:
  - a=0, b=4, op ADD (branch target latched into alu_out).
  - j: pc_write, pc_source=2; next FETCH.
  - jal: as j, plus register_write, destination 2, source 2 (PC already holds +4).
  - jr (R, funct 001000): pc_write, pc_source=3; next FETCH.
  - Undefined opcode/funct: next TRAP.
  - Otherwise: next EXECUTE.
- EXECUTE:
  - R add/sub/and/or/xor: a=1, b=0; next WRITEBACK.
  - sll/srl/sra: a=2, b=0; next WRITEBACK.
  - addi: a=1, b=2, op ADD. andi/ori/xori: a=1, b=3. lui: b=3, op LUI. All next WRITEBACK.
  - lw/sw: a=1, b=2, op ADD; next MEMORY.
  - beq/bne: a=1, b=0, op SUB; pc_write = zero (beq) or !zero (bne), pc_source=1; next FETCH.
- MEMORY:
  - memory_request=1, address_select=1, memory_write=1 for sw.
  - Held until memory_ready; then sw goes to FETCH, lw to WRITEBACK (datapath loads MDR on ready).
- WRITEBACK:
  - register_write=1.
  - Destination 1 for R-type, 0 for I-type.
  - Source 1 for lw, else 0.
  - Next FETCH.
- TRAP: illegal=1, all strobes 0; only reset exits.
- memory_ready outside FETCH/MEMORY is ignored.
- Opcodes (binary):
  - R 000000; addi 001000, andi 001100, ori 001101, xori 001110, lui 001111.
  - lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
  - Funct: add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000.
- CPI: R/I-ALU 4, lw 5, sw 4, branch 3, jump 2, each plus memory wait cycles.

Decomposition:
- Shared package holds:
  - opcode/funct constants;
  - ALU operation codes, shared with the ALU;
  - the state encoding;
  - the select-field encodings.
- One combinational sub-module, alu_operation_decoder: opcode+funct -> operation, a_select/b_select for EXECUTE, plus a legal flag.

Test Plan:
- Reset: resetn low mid-MEMORY -> all outputs 0 at once; after release, state FETCH and memory_request=1 next cycle.
- add r3,r1,r2 (0x00221820), memory_ready tied 1 -> FETCH/DECODE/EXECUTE/WRITEBACK; EXECUTE op=0000, a=1, b=0; WRITEBACK dest=1, src=0; 4 cycles.
- lw r2,8(r1) (0x8C220008), memory_ready delayed 3 cycles in MEMORY -> request held 4 cycles, memory_write=0, WRITEBACK src=1, dest=0.
- beq (0x10220003) with zero=1 -> pc_write=1, pc_source=1 in EXECUTE; repeat with zero=0 -> pc_write=0; bne inverts.
- sra (funct 000011) -> op=1111, a=2; lui -> op=0110, b=3; jal -> DECODE: register_write=1, dest=2, src=2, pc_source=2.
- Opcode 111111 -> TRAP, illegal=1 held 20 cycles with no strobes and memory_ready ignored; resetn clears it.
